receiver_uart: RTL and testbench

Packet receiver for the team UART link. It deserialises bytes from rxd and parses packets of the form cmd, len, data0..data(len-1), sum, where sum = ~(cmd + len + data0 + ... ) mod 256. Payload bytes are written to an external RAM port. Completion or error is reported by single-cycle pulses. It is the counterpart of the packet transmitter and mates with it over one wire.

---
 rtl/receiver_uart_pkg.sv | 29 ++
 rtl/single_rx_uart.sv | 120 ++++++++++++
 rtl/receiver_uart.sv | 148 ++++++++++++++
 tb/tb_receiver_uart.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/receiver_uart_pkg.sv
// Shared types and helpers for the UART packet receiver.
package receiver_uart_pkg;

    typedef enum logic [2:0] {
        PKT_IDLE,
        PKT_CMD,
        PKT_LEN,
        PKT_DATA,
        PKT_SUM
    } pkt_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SUM     = 2'd1,
        ERR_FRAME   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    // Address width for a RAM of the given depth, never below one bit.
    function automatic int clogb2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/single_rx_uart.sv
// Single-byte UART deserialiser: synchroniser, mid-bit sampling, optional parity, stop check.
module single_rx_uart
    import receiver_uart_pkg::*;
#(
    parameter int    CLOCK     = 10_000_000,
    parameter int    BAUD      = 1_000_000,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       byte_start
);

    localparam int BIT_CYC   = CLOCK / BAUD;
    localparam int HALF      = BIT_CYC / 2;
    localparam int CW        = $clog2(BIT_CYC);
    localparam bit PAR_EN    = (PARITY != "NO");
    localparam bit PAR_ODD   = (PARITY == "ODD");
    localparam bit MSB_FIRST = (FIRST_BIT == "MSB");

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic          rxd_p0, rxd_p1, rxd_p2;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          par_err;
    logic          bit_end;
    logic          rdy_p0, err_p0;

    assign bit_end = (cnt == CW'(BIT_CYC - 1));
    assign par_err = PAR_EN && (((^shreg) ^ par_bit ^ PAR_ODD) != 1'b0);
    assign rx_byte = shreg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rxd_p0     <= 1'b1;
            rxd_p1     <= 1'b1;
            rxd_p2     <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rdy_p0     <= 1'b0;
            err_p0     <= 1'b0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            byte_start <= 1'b0;
        end else begin
            rxd_p0     <= rxd;
            rxd_p1     <= rxd_p0;
            rxd_p2     <= rxd_p1;
            rdy_p0     <= 1'b0;
            byte_start <= 1'b0;
            byte_valid <= rdy_p0;
            byte_err   <= rdy_p0 & err_p0;
            cnt        <= cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (rxd_p2 && !rxd_p1) state <= S_START;
                end
                S_START: begin
                    // A start bit that is high again at its midpoint was a glitch.
                    if (cnt == CW'(HALF - 1)) begin
                        cnt <= '0;
                        if (rxd_p1) begin
                            state <= S_IDLE;
                        end else begin
                            state      <= S_DATA;
                            bit_idx    <= '0;
                            byte_start <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= PAR_EN ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        state  <= S_IDLE;
                        rdy_p0 <= 1'b1;
                        err_p0 <= !rxd_p1 || par_err;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DATA && bit_end) begin
            shreg <= MSB_FIRST ? {shreg[6:0], rxd_p1} : {rxd_p1, shreg[7:1]};
        end
        if (state == S_PAR && bit_end) begin
            par_bit <= rxd_p1;
        end
    end

endmodule

// File: rtl/receiver_uart.sv
// Packet receiver: parses cmd, len, payload, checksum from the byte stream and writes payload to RAM.
module receiver_uart
    import receiver_uart_pkg::*;
#(
    parameter int    CLOCK     = 10_000_000,
    parameter int    BAUD      = 1_000_000,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB",
    parameter int    NUMBER    = 256,
    parameter int    TIMEOUT   = 20,
    parameter int    AW        = clogb2(NUMBER)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rxd,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_en,
    output logic [7:0]    cmd_rx,
    output logic [AW-1:0] len_rx,
    output logic          pckt_done,
    output logic          pckt_err,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam int BIT_CYC = CLOCK / BAUD;
    localparam int TO_CYC  = TIMEOUT * BIT_CYC;
    localparam int TW      = $clog2(TO_CYC + 1);

    logic [7:0]    rx_byte;
    logic          byte_valid, byte_err, byte_start;
    pkt_state_t    state;
    logic [7:0]    cmd_q, sum_q;
    logic [AW-1:0] len_q, idx_q;
    logic [TW-1:0] tcnt;
    logic          len_ok, sum_ok, timed_out;

    single_rx_uart #(
        .CLOCK    (CLOCK),
        .BAUD     (BAUD),
        .PARITY   (PARITY),
        .FIRST_BIT(FIRST_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .byte_err  (byte_err),
        .byte_start(byte_start)
    );

    assign len_ok    = int'(rx_byte) <= NUMBER - 1;
    assign sum_ok    = (rx_byte == ~sum_q);
    assign timed_out = (tcnt == TW'(TO_CYC - 1));
    assign busy      = (state != PKT_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= PKT_IDLE;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            wr_addr   <= '0;
            cmd_rx    <= '0;
            len_rx    <= '0;
            pckt_done <= 1'b0;
            pckt_err  <= 1'b0;
            err_code  <= ERR_NONE;
            idx_q     <= '0;
            tcnt      <= '0;
        end else begin
            wr_en     <= 1'b0;
            pckt_done <= 1'b0;
            pckt_err  <= 1'b0;
            tcnt      <= (byte_start || state == PKT_IDLE) ? '0 : tcnt + 1'b1;
            if (byte_valid && byte_err) begin
                // A bad cmd byte means no packet has started yet, so it is dropped quietly.
                if (state != PKT_IDLE && state != PKT_CMD) begin
                    pckt_err <= 1'b1;
                    err_code <= ERR_FRAME;
                end
                state <= PKT_IDLE;
            end else if (byte_valid) begin
                case (state)
                    PKT_CMD: state <= PKT_LEN;
                    PKT_LEN: begin
                        if (!len_ok) begin
                            pckt_err <= 1'b1;
                            err_code <= ERR_FRAME;
                            state    <= PKT_IDLE;
                        end else if (rx_byte == 8'd0) begin
                            state <= PKT_SUM;
                        end else begin
                            idx_q <= '0;
                            state <= PKT_DATA;
                        end
                    end
                    PKT_DATA: begin
                        wr_en   <= 1'b1;
                        wr_data <= rx_byte;
                        wr_addr <= idx_q;
                        if (idx_q == len_q - 1'b1) state <= PKT_SUM;
                        else                       idx_q <= idx_q + 1'b1;
                    end
                    PKT_SUM: begin
                        if (sum_ok) begin
                            pckt_done <= 1'b1;
                            cmd_rx    <= cmd_q;
                            len_rx    <= len_q;
                            err_code  <= ERR_NONE;
                        end else begin
                            pckt_err <= 1'b1;
                            err_code <= ERR_SUM;
                        end
                        state <= PKT_IDLE;
                    end
                    default: state <= PKT_IDLE;
                endcase
            end else if (state == PKT_IDLE) begin
                if (byte_start) state <= PKT_CMD;
            end else if (timed_out) begin
                pckt_err <= 1'b1;
                err_code <= ERR_TIMEOUT;
                state    <= PKT_IDLE;
            end
        end
    end

    // Running checksum and packet header, updated only on clean bytes.
    always_ff @(posedge clk) begin
        if (byte_valid && !byte_err) begin
            case (state)
                PKT_CMD: begin
                    cmd_q <= rx_byte;
                    sum_q <= rx_byte;
                end
                PKT_LEN: begin
                    len_q <= rx_byte[AW-1:0];
                    sum_q <= sum_q + rx_byte;
                end
                PKT_DATA: sum_q <= sum_q + rx_byte;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_receiver_uart.sv
// Bench for receiver_uart: plain 8N1 LSB-first instance and an even-parity MSB-first instance.
module tb_receiver_uart;

    localparam int BC     = 10;
    localparam int TO_CYC = 20 * BC;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd       [2];
    logic [7:0] wr_data   [2];
    logic [7:0] wr_addr   [2];
    logic       wr_en     [2];
    logic [7:0] cmd_rx    [2];
    logic [7:0] len_rx    [2];
    logic       pckt_done [2];
    logic       pckt_err  [2];
    logic [1:0] err_code  [2];
    logic       busy      [2];

    always #5 clk = ~clk;

    receiver_uart dut0 (
        .clk(clk), .reset(reset), .rxd(rxd[0]),
        .wr_data(wr_data[0]), .wr_addr(wr_addr[0]), .wr_en(wr_en[0]),
        .cmd_rx(cmd_rx[0]), .len_rx(len_rx[0]),
        .pckt_done(pckt_done[0]), .pckt_err(pckt_err[0]),
        .err_code(err_code[0]), .busy(busy[0])
    );

    receiver_uart #(.PARITY("EVEN"), .FIRST_BIT("MSB")) dut1 (
        .clk(clk), .reset(reset), .rxd(rxd[1]),
        .wr_data(wr_data[1]), .wr_addr(wr_addr[1]), .wr_en(wr_en[1]),
        .cmd_rx(cmd_rx[1]), .len_rx(len_rx[1]),
        .pckt_done(pckt_done[1]), .pckt_err(pckt_err[1]),
        .err_code(err_code[1]), .busy(busy[1])
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_done [2] = '{0, 0};
    int          n_err  [2] = '{0, 0};
    int          n_both [2] = '{0, 0};
    int          n_busy [2] = '{0, 0};
    logic [16:0] wr_log [$];
    logic [7:0]  pkt    [$];
    logic [15:0] exp_w  [$];
    logic [7:0]  exp_cmd  [2] = '{8'h00, 8'h00};
    logic [7:0]  exp_len  [2] = '{8'h00, 8'h00};
    logic [1:0]  exp_code [2] = '{2'd0, 2'd0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pckt_done[i]) n_done[i]++;
            if (pckt_err[i]) n_err[i]++;
            if (pckt_done[i] && pckt_err[i]) n_both[i]++;
            if (busy[i]) n_busy[i]++;
        end
        if (wr_en[0]) wr_log.push_back({1'b0, wr_addr[0], wr_data[0]});
        if (wr_en[1]) wr_log.push_back({1'b1, wr_addr[1], wr_data[1]});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int ln, input logic v);
        rxd[ln] = v;
        repeat (BC) @(negedge clk);
    endtask

    task automatic idle_bits(input int ln, input int nbits);
        rxd[ln] = 1'b1;
        repeat (nbits * BC) @(negedge clk);
    endtask

    // Line 0 is 8N1 LSB-first; line 1 is MSB-first with an even parity bit.
    task automatic send_byte(input int ln, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        drive_bit(ln, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(ln, (ln == 1) ? b[7-i] : b[i]);
        if (ln == 1) drive_bit(ln, (^b) ^ bad_par);
        drive_bit(ln, !bad_stop);
        rxd[ln] = 1'b1;
    endtask

    task automatic make_pkt(input logic [7:0] c, input int len, input bit good);
        logic [7:0] s;
        pkt.delete();
        pkt.push_back(c);
        pkt.push_back(8'(len));
        s = c + 8'(len);
        for (int i = 0; i < len; i++) begin
            pkt.push_back(8'($urandom_range(0, 255)));
            s = s + pkt[i+2];
        end
        pkt.push_back(good ? ~s : s);
    endtask

    task automatic check_outputs_zero(input int ln, input string tag);
        check($sformatf("%s_cmd_rx%0d", tag, ln), 32'(cmd_rx[ln]), 32'h0);
        check($sformatf("%s_len_rx%0d", tag, ln), 32'(len_rx[ln]), 32'h0);
        check($sformatf("%s_err_code%0d", tag, ln), 32'(err_code[ln]), 32'h0);
        check($sformatf("%s_pulses%0d", tag, ln), {29'd0, pckt_done[ln], pckt_err[ln], wr_en[ln]}, 32'h0);
        check($sformatf("%s_wr_bus%0d", tag, ln), {16'd0, wr_addr[ln], wr_data[ln]}, 32'h0);
        check($sformatf("%s_busy%0d", tag, ln), 32'(busy[ln]), 32'h0);
    endtask

    // Sends the first n_send bytes of pkt (byte bad_idx corrupted, -1 for none), then
    // compares the DUT against the outcome the packet rules predict.
    task automatic run_packet(input int ln, input int n_send, input int bad_idx, input bit bad_stop,
                              input string tag);
        int         d0, e0, w0, len, full, lim, outcome, nw;
        logic [7:0] s;
        logic [1:0] code;
        d0 = n_done[ln];
        e0 = n_err[ln];
        w0 = wr_log.size();
        for (int i = 0; i < n_send; i++) begin
            send_byte(ln, pkt[i], (i == bad_idx) && !bad_stop, (i == bad_idx) && bad_stop);
            if (i != n_send - 1) idle_bits(ln, $urandom_range(0, 2));
        end
        len  = int'(pkt[1]);
        full = len + 3;
        if (bad_idx < 0 && n_send < full) begin
            rxd[ln] = 1'b1;
            repeat (TO_CYC + 5 * BC) @(negedge clk);
        end else begin
            idle_bits(ln, 3);
        end

        lim = (bad_idx >= 0) ? bad_idx : n_send;
        exp_w.delete();
        for (int i = 2; i < 2 + len && i < lim; i++) exp_w.push_back({8'(i - 2), pkt[i]});
        outcome = 0;
        code    = exp_code[ln];
        if (bad_idx == 0) begin
            outcome = 0;
        end else if (bad_idx > 0) begin
            outcome = 2;
            code    = 2'd2;
        end else if (n_send < full) begin
            outcome = 2;
            code    = 2'd3;
        end else begin
            s = 8'h00;
            for (int i = 0; i < full - 1; i++) s = s + pkt[i];
            if (pkt[full-1] == ~s) begin
                outcome     = 1;
                code        = 2'd0;
                exp_cmd[ln] = pkt[0];
                exp_len[ln] = pkt[1];
            end else begin
                outcome = 2;
                code    = 2'd1;
            end
        end
        exp_code[ln] = code;

        nw = 0;
        for (int i = w0; i < wr_log.size(); i++) if (wr_log[i][16] == 1'(ln)) nw++;
        check($sformatf("%s_nwrites", tag), 32'(nw), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size(); k++) begin
            check($sformatf("%s_write%0d", tag, k),
                  (w0 + k < wr_log.size()) ? {15'd0, wr_log[w0+k]} : 32'hDEAD_BEEF,
                  {15'd0, 1'(ln), exp_w[k]});
        end
        check($sformatf("%s_done", tag), 32'(n_done[ln] - d0), (outcome == 1) ? 32'd1 : 32'd0);
        check($sformatf("%s_err", tag), 32'(n_err[ln] - e0), (outcome == 2) ? 32'd1 : 32'd0);
        check($sformatf("%s_err_code", tag), 32'(err_code[ln]), 32'(exp_code[ln]));
        check($sformatf("%s_cmd_rx", tag), 32'(cmd_rx[ln]), 32'(exp_cmd[ln]));
        check($sformatf("%s_len_rx", tag), 32'(len_rx[ln]), 32'(exp_len[ln]));
        check($sformatf("%s_busy", tag), 32'(busy[ln]), 32'h0);
    endtask

    initial begin
        int b0, d0, e0, w0;
        reset = 1'b0;
        rxd   = '{1'b1, 1'b1};
        repeat (3) @(negedge clk);
        check_outputs_zero(0, "reset");
        check_outputs_zero(1, "reset");
        reset = 1'b1;
        idle_bits(0, 2);

        pkt = '{8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h3C};
        run_packet(0, 6, -1, 1'b0, "good_5a");
        pkt = '{8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h3D};
        run_packet(0, 6, -1, 1'b0, "badsum_5a");
        pkt = '{8'h01, 8'h00, 8'hFE};
        run_packet(0, 3, -1, 1'b0, "len0");

        // Short low glitch on an idle line
        b0 = n_busy[0]; d0 = n_done[0]; e0 = n_err[0]; w0 = wr_log.size();
        rxd[0] = 1'b0;
        repeat (3) @(negedge clk);
        idle_bits(0, 4);
        check("glitch_busy", 32'(n_busy[0] - b0), 32'd0);
        check("glitch_pulses", 32'(n_done[0] - d0 + n_err[0] - e0), 32'd0);
        check("glitch_writes", 32'(wr_log.size() - w0), 32'd0);

        pkt = '{8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h3C};
        run_packet(0, 3, -1, 1'b0, "timeout");
        make_pkt(8'hC3, 5, 1'b1);
        run_packet(0, pkt.size(), -1, 1'b0, "after_to");

        for (int r = 0; r < 10; r++) begin
            make_pkt(8'($urandom_range(0, 255)), $urandom_range(0, 6), $urandom_range(0, 3) != 0);
            run_packet(0, pkt.size(), -1, 1'b0, $sformatf("rand%0d", r));
        end

        make_pkt(8'hA5, 4, 1'b1);
        run_packet(1, pkt.size(), -1, 1'b0, "par_good");
        make_pkt(8'h3C, 4, 1'b1);
        run_packet(1, 2, 1, 1'b0, "par_badlen");
        make_pkt(8'h77, 4, 1'b1);
        run_packet(1, 4, 3, 1'b1, "par_badstop");
        make_pkt(8'h81, 3, 1'b1);
        run_packet(1, pkt.size(), -1, 1'b0, "par_recover");

        // Reset pulse while a payload byte is on the wire (line held high at that moment)
        make_pkt(8'h42, 4, 1'b1);
        send_byte(0, pkt[0], 1'b0, 1'b0);
        send_byte(0, pkt[1], 1'b0, 1'b0);
        send_byte(0, pkt[2], 1'b0, 1'b0);
        drive_bit(0, 1'b0);
        rxd[0] = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero(0, "midrst");
        check_outputs_zero(1, "midrst");
        reset = 1'b1;
        exp_cmd  = '{8'h00, 8'h00};
        exp_len  = '{8'h00, 8'h00};
        exp_code = '{2'd0, 2'd0};
        idle_bits(0, 25);
        make_pkt(8'h9E, 6, 1'b1);
        run_packet(0, pkt.size(), -1, 1'b0, "post_rst");

        check("both_pulses0", 32'(n_both[0]), 32'd0);
        check("both_pulses1", 32'(n_both[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
